uart_transceiver: RTL and testbench

Full-duplex UART with runtime-configurable framing: 5–8 data bits, 1 or 2 stop bits, optional even or odd parity. It sits between a serial line pair (rx/tx) with RTS/CTS hardware flow control and a parallel byte interface on the system clock. Receive and transmit paths are independent. Both paths share one 16x-oversampling baud tick.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_if.sv | 20 ++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_transceiver.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_transceiver.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transceiver: FSM state encodings,
// data-length encoding with its bit-count mapping, and parity selectors.
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_WAIT_CTS,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   localparam logic [1:0] DBITS_5 = 2'b00;
   localparam logic [1:0] DBITS_6 = 2'b01;
   localparam logic [1:0] DBITS_7 = 2'b10;
   localparam logic [1:0] DBITS_8 = 2'b11;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   function automatic logic [3:0] data_bits(input logic [1:0] enc);
      case (enc)
         DBITS_5: return 4'd5;
         DBITS_6: return 4'd6;
         DBITS_7: return 4'd7;
         default: return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/uart_if.sv
// Parallel byte-side interface of the UART: received word and status,
// transmit word and request, transmit completion.
interface uart_if;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       parity_error;
   logic [7:0] tx_data;
   logic       start_tx;
   logic       tx_done;

   modport master (
      input  rx_data, rx_done, parity_error, tx_done,
      output tx_data, start_tx
   );

   modport slave (
      output rx_data, rx_done, parity_error, tx_done,
      input  tx_data, start_tx
   );
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running oversampling tick generator shared by the rx and tx paths.
// One-cycle tick each time the divider wraps from DIV-1 back to 0.
module uart_baud_gen #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int DIV  = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
   localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset_n) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART with per-frame latched framing (5-8 data, 1/2 stop,
// optional even/odd parity) and RTS/CTS flow control.
//
// rx state  | meaning
// RX_IDLE   | line idle, rts_n low, waiting for falling edge
// RX_START  | verifying start bit at mid-bit
// RX_DATA   | sampling data bits LSB first
// RX_PARITY | sampling parity bit
// RX_STOP   | sampling stop bit(s); low stop drops the frame
//
// tx state    | meaning
// TX_IDLE     | waiting for start_tx
// TX_WAIT_CTS | word latched, waiting for cts_n low on a tick
// TX_START    | driving start bit
// TX_DATA     | driving data bits LSB first
// TX_PARITY   | driving parity bit
// TX_STOP     | driving stop bit(s)
module uart_transceiver #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   input  logic [1:0] data_bit_num,
   input  logic       stop_bit_num,
   input  logic       parity_en,
   input  logic       parity_type,
   output logic       rts_n,
   input  logic       cts_n,
   output logic       tx,
   uart_if.slave      bus
);
   import uart_pkg::*;

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);

   logic tick;

   uart_baud_gen #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_baud_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick)
   );

   // ---------------- receiver ----------------
   logic [1:0]    rx_sync;
   logic          rx_s, rx_prev, rx_fall;
   rx_state_t     rx_state, rx_state_nxt;
   logic [TW-1:0] rx_tick_cnt;
   logic [2:0]    rx_bit_cnt, rx_last;
   logic          rx_stop_cnt, rx_stop2, rx_par_en, rx_par_type, rx_par_acc;
   logic [7:0]    rx_shift;
   logic          rx_bit_end, rx_mid, rx_good;

   assign rx_s       = rx_sync[1];
   assign rx_fall    = rx_prev & ~rx_s;
   assign rx_bit_end = tick & (rx_tick_cnt == TICK_LAST);
   assign rx_mid     = tick & (rx_tick_cnt == TICK_MID);

   always_ff @(posedge clk) begin
      if (reset_n) begin
         rx_sync <= 2'b11;
         rx_prev <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[0], rx};
         rx_prev <= rx_s;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n) rx_state <= RX_IDLE;
      else         rx_state <= rx_state_nxt;
   end

   always_comb begin
      rx_state_nxt = rx_state;
      rx_good      = 1'b0;
      case (rx_state)
         RX_IDLE:   if (rx_fall) rx_state_nxt = RX_START;
         RX_START:  if (rx_mid) rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:   if (rx_bit_end && rx_bit_cnt == rx_last)
                       rx_state_nxt = rx_par_en ? RX_PARITY : RX_STOP;
         RX_PARITY: if (rx_bit_end) rx_state_nxt = RX_STOP;
         RX_STOP: begin
            if (rx_bit_end) begin
               if (!rx_s) begin
                  rx_state_nxt = RX_IDLE;
               end else if (rx_stop_cnt == rx_stop2) begin
                  rx_state_nxt = RX_IDLE;
                  rx_good      = 1'b1;
               end
            end
         end
         default:   rx_state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         rx_tick_cnt      <= '0;
         rx_bit_cnt       <= '0;
         rx_stop_cnt      <= 1'b0;
         rx_last          <= '0;
         rx_stop2         <= 1'b0;
         rx_par_en        <= 1'b0;
         rx_par_type      <= 1'b0;
         rx_par_acc       <= 1'b0;
         rx_shift         <= '0;
         rts_n            <= 1'b1;
         bus.rx_data      <= '0;
         bus.rx_done      <= 1'b0;
         bus.parity_error <= 1'b0;
      end else begin
         bus.rx_done <= rx_good;
         rts_n       <= (rx_state_nxt != RX_IDLE);
         if (rx_state == RX_IDLE) begin
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_stop_cnt <= 1'b0;
            rx_par_acc  <= 1'b0;
            rx_shift    <= '0;
            if (rx_fall) begin
               rx_last     <= 3'(data_bits(data_bit_num) - 4'd1);
               rx_stop2    <= stop_bit_num;
               rx_par_en   <= parity_en;
               rx_par_type <= parity_type;
            end
         end else if (tick) begin
            // START restarts the count at mid-bit so later samples land mid-bit
            rx_tick_cnt <= (rx_tick_cnt == TICK_LAST ||
                            (rx_state == RX_START && rx_tick_cnt == TICK_MID))
                           ? '0 : rx_tick_cnt + 1'b1;
            if (rx_bit_end) begin
               case (rx_state)
                  RX_DATA: begin
                     rx_shift[rx_bit_cnt] <= rx_s;
                     rx_par_acc           <= rx_par_acc ^ rx_s;
                     rx_bit_cnt           <= rx_bit_cnt + 1'b1;
                  end
                  RX_PARITY: rx_par_acc  <= rx_par_acc ^ rx_s;
                  RX_STOP:   rx_stop_cnt <= 1'b1;
                  default: ;
               endcase
            end
         end
         if (rx_good) begin
            bus.rx_data      <= rx_shift;
            bus.parity_error <= rx_par_en & (rx_par_acc != rx_par_type);
         end
      end
   end

   // ---------------- transmitter ----------------
   tx_state_t     tx_state, tx_state_nxt;
   logic [TW-1:0] tx_tick_cnt;
   logic [2:0]    tx_bit_cnt, tx_last;
   logic          tx_stop_cnt, tx_stop2, tx_par_en, tx_par_bit;
   logic [7:0]    tx_shift, tx_mask;
   logic          tx_bit_end, tx_fin, tx_line;

   assign tx_bit_end = tick & (tx_tick_cnt == TICK_LAST);
   assign tx_mask    = 8'hFF >> (4'd8 - data_bits(data_bit_num));

   always_ff @(posedge clk) begin
      if (reset_n) tx_state <= TX_IDLE;
      else         tx_state <= tx_state_nxt;
   end

   always_comb begin
      tx_state_nxt = tx_state;
      tx_fin       = 1'b0;
      tx_line      = 1'b1;
      case (tx_state)
         TX_IDLE:     if (bus.start_tx) tx_state_nxt = TX_WAIT_CTS;
         TX_WAIT_CTS: if (tick && !cts_n) tx_state_nxt = TX_START;
         TX_START: begin
            tx_line = 1'b0;
            if (tx_bit_end) tx_state_nxt = TX_DATA;
         end
         TX_DATA: begin
            tx_line = tx_shift[tx_bit_cnt];
            if (tx_bit_end && tx_bit_cnt == tx_last)
               tx_state_nxt = tx_par_en ? TX_PARITY : TX_STOP;
         end
         TX_PARITY: begin
            tx_line = tx_par_bit;
            if (tx_bit_end) tx_state_nxt = TX_STOP;
         end
         TX_STOP: begin
            if (tx_bit_end && tx_stop_cnt == tx_stop2) begin
               tx_state_nxt = TX_IDLE;
               tx_fin       = 1'b1;
            end
         end
         default:     tx_state_nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         tx_tick_cnt <= '0;
         tx_bit_cnt  <= '0;
         tx_stop_cnt <= 1'b0;
         tx_last     <= '0;
         tx_stop2    <= 1'b0;
         tx_par_en   <= 1'b0;
         tx_par_bit  <= 1'b0;
         tx_shift    <= '0;
         tx          <= 1'b1;
         bus.tx_done <= 1'b0;
      end else begin
         tx          <= tx_line;
         bus.tx_done <= tx_fin;
         if (tx_state == TX_IDLE || tx_state == TX_WAIT_CTS) begin
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_stop_cnt <= 1'b0;
            if (tx_state == TX_IDLE && bus.start_tx) begin
               tx_shift   <= bus.tx_data & tx_mask;
               tx_last    <= 3'(data_bits(data_bit_num) - 4'd1);
               tx_stop2   <= stop_bit_num;
               tx_par_en  <= parity_en;
               tx_par_bit <= (^(bus.tx_data & tx_mask)) ^ parity_type;
            end
         end else if (tick) begin
            tx_tick_cnt <= (tx_tick_cnt == TICK_LAST) ? '0 : tx_tick_cnt + 1'b1;
            if (tx_bit_end) begin
               if (tx_state == TX_DATA) tx_bit_cnt  <= tx_bit_cnt + 1'b1;
               if (tx_state == TX_STOP) tx_stop_cnt <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver at default rates (432 clk per bit).
module tb_uart_transceiver;

   localparam int BIT = 432;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       rx = 1'b1;
   logic       cts_n = 1'b1;
   logic [1:0] dbn = 2'b11;
   logic       sbn = 1'b0;
   logic       pen = 1'b0;
   logic       ptype = 1'b0;
   logic       rts_n, tx;

   int rx_done_cnt = 0;
   int tx_done_cnt = 0;
   int n_vec = 0;
   int n_err = 0;
   int exp_rx = 0;
   int exp_tx = 0;

   uart_if bus ();

   uart_transceiver dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx           (rx),
      .data_bit_num (dbn),
      .stop_bit_num (sbn),
      .parity_en    (pen),
      .parity_type  (ptype),
      .rts_n        (rts_n),
      .cts_n        (cts_n),
      .tx           (tx),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.rx_done === 1'b1) rx_done_cnt++;
      if (bus.tx_done === 1'b1) tx_done_cnt++;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input logic [1:0] d, input logic s, input logic pe, input logic pt);
      dbn = d; sbn = s; pen = pe; ptype = pt;
   endtask

   task automatic rx_frame(input logic [7:0] d, input int nbits, input bit par_on,
                           input bit par_v, input bit two_stop, input bit stop_b,
                           output bit rts_hi);
      rx = 1'b0;
      wait_cyc(BIT / 2);
      rts_hi = (rts_n === 1'b1);
      wait_cyc(BIT / 2);
      for (int i = 0; i < nbits; i++) begin
         rx = d[i];
         wait_cyc(BIT / 2);
         rts_hi = rts_hi & (rts_n === 1'b1);
         wait_cyc(BIT / 2);
      end
      if (par_on) begin
         rx = par_v;
         wait_cyc(BIT);
      end
      rx = 1'b1;
      wait_cyc(BIT);
      if (two_stop) begin
         rx = stop_b;
         wait_cyc(BIT);
      end
      rx = 1'b1;
   endtask

   task automatic pulse_start(input logic [7:0] d);
      bus.tx_data  = d;
      bus.start_tx = 1'b1;
      wait_cyc(1);
      bus.start_tx = 1'b0;
   endtask

   task automatic wait_tx_fall(input string tag);
      int w = 0;
      while (tx !== 1'b0 && w < 600) begin
         wait_cyc(1);
         w++;
      end
      check(tag, 32'(w < 600), 32'd1);
   endtask

   task automatic tx_frame_check(input logic [7:0] d, input int nbits, input bit par_on,
                                 input bit par_exp, input int nstop);
      wait_tx_fall("tx_start_found");
      wait_cyc(BIT / 2);
      check("tx_start_bit", 32'(tx), 32'd0);
      for (int i = 0; i < nbits; i++) begin
         wait_cyc(BIT);
         check($sformatf("tx_data_bit%0d", i), 32'(tx), 32'(d[i]));
      end
      if (par_on) begin
         wait_cyc(BIT);
         check("tx_parity_bit", 32'(tx), 32'(par_exp));
      end
      for (int i = 0; i < nstop; i++) begin
         wait_cyc(BIT);
         check("tx_stop_bit", 32'(tx), 32'd1);
      end
   endtask

   initial begin
      bit rts_hi;
      int lows;
      bus.tx_data  = 8'h00;
      bus.start_tx = 1'b0;

      // reset held for 435 cycles
      wait_cyc(430);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_rts_n", 32'(rts_n), 32'd1);
      check("rst_rx_done", 32'(bus.rx_done), 32'd0);
      check("rst_rx_data", 32'(bus.rx_data), 32'h00);
      check("rst_parity_error", 32'(bus.parity_error), 32'd0);
      check("rst_tx_done", 32'(bus.tx_done), 32'd0);
      wait_cyc(5);
      reset_n = 1'b0;
      wait_cyc(5);
      check("post_rst_rts_n", 32'(rts_n), 32'd0);

      // 8N1 rx of 0xA5
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      rx_frame(8'hA5, 8, 0, 0, 0, 0, rts_hi);
      exp_rx++;
      check("rx8n1_rts_busy", 32'(rts_hi), 32'd1);
      check("rx8n1_data", 32'(bus.rx_data), 32'hA5);
      check("rx8n1_done_cnt", 32'(rx_done_cnt), 32'(exp_rx));
      check("rx8n1_perr", 32'(bus.parity_error), 32'd0);
      check("rx8n1_rts_idle", 32'(rts_n), 32'd0);

      // 7-bit 0x35 has four ones: even wants parity 0, odd wants parity 1
      set_cfg(2'b10, 1'b0, 1'b1, 1'b0);
      rx_frame(8'h35, 7, 1, 1, 0, 0, rts_hi);
      exp_rx++;
      check("rx7e1_bad_data", 32'(bus.rx_data), 32'h35);
      check("rx7e1_bad_perr", 32'(bus.parity_error), 32'd1);
      rx_frame(8'h35, 7, 1, 0, 0, 0, rts_hi);
      exp_rx++;
      check("rx7e1_good_perr", 32'(bus.parity_error), 32'd0);
      set_cfg(2'b10, 1'b0, 1'b1, 1'b1);
      rx_frame(8'h35, 7, 1, 0, 0, 0, rts_hi);
      exp_rx++;
      check("rx7o1_bad_perr", 32'(bus.parity_error), 32'd1);
      rx_frame(8'h35, 7, 1, 1, 0, 0, rts_hi);
      exp_rx++;
      check("rx7o1_good_perr", 32'(bus.parity_error), 32'd0);
      check("rx7_done_cnt", 32'(rx_done_cnt), 32'(exp_rx));

      // 5-bit 2-stop: only the low 5 line bits of 0xEA are sent -> 0x0A
      set_cfg(2'b00, 1'b1, 1'b0, 1'b0);
      rx_frame(8'hEA, 5, 0, 0, 1, 1, rts_hi);
      exp_rx++;
      check("rx5n2_data", 32'(bus.rx_data), 32'h0A);
      check("rx5n2_done_cnt", 32'(rx_done_cnt), 32'(exp_rx));
      rx_frame(8'h1F, 5, 0, 0, 1, 0, rts_hi);
      wait_cyc(BIT);
      check("rx_framing_done_cnt", 32'(rx_done_cnt), 32'(exp_rx));
      check("rx_framing_data_held", 32'(bus.rx_data), 32'h0A);

      // 100-cycle low glitch
      rx = 1'b0;
      wait_cyc(50);
      check("glitch_rts_busy", 32'(rts_n), 32'd1);
      wait_cyc(50);
      rx = 1'b1;
      wait_cyc(2 * BIT);
      check("glitch_done_cnt", 32'(rx_done_cnt), 32'(exp_rx));
      check("glitch_rts_idle", 32'(rts_n), 32'd0);

      // tx 0xC3 8O1 held off by cts_n
      set_cfg(2'b11, 1'b0, 1'b1, 1'b1);
      cts_n = 1'b1;
      pulse_start(8'hC3);
      lows = 0;
      for (int i = 0; i < 1000; i++) begin
         wait_cyc(1);
         if (tx !== 1'b1) lows++;
      end
      check("tx_cts_hold", 32'(lows), 32'd0);
      cts_n = 1'b0;
      tx_frame_check(8'hC3, 8, 1, 1, 1);
      wait_cyc(300);
      exp_tx++;
      check("tx8o1_done_cnt", 32'(tx_done_cnt), 32'(exp_tx));
      check("tx8o1_idle", 32'(tx), 32'd1);

      // reset in rx DATA
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      rx = 1'b0;
      wait_cyc(2 * BIT);
      rx = 1'b1;
      wait_cyc(BIT / 2);
      reset_n = 1'b1;
      wait_cyc(5);
      check("rxabort_rts_n", 32'(rts_n), 32'd1);
      check("rxabort_rx_data", 32'(bus.rx_data), 32'h00);
      check("rxabort_tx", 32'(tx), 32'd1);
      wait_cyc(20);
      reset_n = 1'b0;
      wait_cyc(20);
      check("rxabort_rts_idle", 32'(rts_n), 32'd0);
      check("rxabort_done_cnt", 32'(rx_done_cnt), 32'(exp_rx));
      rx_frame(8'h3C, 8, 0, 0, 0, 0, rts_hi);
      exp_rx++;
      check("rx_after_abort_data", 32'(bus.rx_data), 32'h3C);
      check("rx_after_abort_cnt", 32'(rx_done_cnt), 32'(exp_rx));

      // reset in tx DATA
      pulse_start(8'h96);
      wait_tx_fall("txabort_start_found");
      wait_cyc(3 * BIT);
      reset_n = 1'b1;
      wait_cyc(5);
      check("txabort_tx", 32'(tx), 32'd1);
      check("txabort_rx_data", 32'(bus.rx_data), 32'h00);
      wait_cyc(20);
      reset_n = 1'b0;
      wait_cyc(BIT);
      check("txabort_done_cnt", 32'(tx_done_cnt), 32'(exp_tx));
      pulse_start(8'h96);
      tx_frame_check(8'h96, 8, 0, 0, 1);
      wait_cyc(300);
      exp_tx++;
      check("tx_after_abort_cnt", 32'(tx_done_cnt), 32'(exp_tx));
      check("rx_cnt_final", 32'(rx_done_cnt), 32'(exp_rx));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
